cache_wb_assoc: RTL and testbench

//  Parametrised N-way set-associative write-back, write-allocate data cache between the core LSU and the AXI master adapter.

---
 rtl/cache_wb_assoc.sv | 219 +++++++++++++++++++++
 tb/tb_cache_wb_assoc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_wb_assoc.sv
// N-way set-associative write-back/write-allocate data cache, true-LRU; optional counters via CACHE_WB_ASSOC_STATS_EN.
// Latency: hit done 3 cycles from accept; clean miss 4+WPL+ack waits; dirty miss adds a WPL-beat write-back plus 1 idle cycle.
// Backpressure: one request in flight, accepted only while cpu_rdy_o=1; memory beats advance only on mem_ack_i.
module cache_wb_assoc #(
    parameter int WAYS    = 4,
    parameter int INDEX_W = 8,
    parameter int WPL     = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [DATA_W/8-1:0] cpu_be_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_wdata_i,
    output logic                cpu_rdy_o,
    output logic                cpu_done_o,
    output logic [DATA_W-1:0]   cpu_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef CACHE_WB_ASSOC_STATS_EN
    ,
    output logic [31:0]         stat_hit_o,
    output logic [31:0]         stat_miss_o,
    output logic [31:0]         stat_wb_o
`endif
);
    localparam int BYTES = DATA_W / 8;
    localparam int BO_W  = $clog2(BYTES);
    localparam int WO_W  = $clog2(WPL);
    localparam int OFF_W = WO_W + BO_W;
    localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam int SETS  = 2 ** INDEX_W;

    typedef struct packed {
        logic             dirty;
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_t;
    typedef logic [WPL-1:0][DATA_W-1:0] line_t;
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOKUP, S_WB, S_REFILL, S_MERGE, S_RESP} state_t;

    state_t             state;
    tag_t               tag_mem  [SETS][WAYS];
    line_t              data_mem [SETS][WAYS];
    tag_t               tag_rd   [WAYS];
    line_t              rd_line  [WAYS];
    logic [WAY_W-1:0]   age_q    [SETS][WAYS];
    line_t              line_buf, merged_line;
    logic [INDEX_W-1:0] init_cnt, req_idx, cpu_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [WO_W-1:0]    req_off, beat, beat_nx;
    logic [BYTES-1:0]   req_be;
    logic [DATA_W-1:0]  req_wdata;
    logic               req_we;
    logic [WAY_W-1:0]   way_q, hit_way, inv_way, lru_way, vic_way, sel_way;
    logic               hit, inv_found, vic_dirty;
    wire                unused_addr_bits = ^cpu_addr_i[BO_W-1:0];

    assign cpu_idx = cpu_addr_i[OFF_W +: INDEX_W];
    assign beat_nx = beat + WO_W'(1);

    always_comb begin
        hit = 1'b0; hit_way = '0; inv_found = 1'b0; inv_way = '0; lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && tag_rd[w].valid && tag_rd[w].tag == req_tag) begin
                hit = 1'b1; hit_way = WAY_W'(w);
            end
            if (!inv_found && !tag_rd[w].valid) begin
                inv_found = 1'b1; inv_way = WAY_W'(w);
            end
            if (age_q[req_idx][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
        end
        vic_way   = inv_found ? inv_way : lru_way;
        vic_dirty = tag_rd[vic_way].valid && tag_rd[vic_way].dirty;
        sel_way   = hit ? hit_way : vic_way;
    end

    // Store bytes are merged over whatever line is buffered (hit copy or refilled line).
    always_comb begin
        merged_line = line_buf;
        if (req_we)
            for (int b = 0; b < BYTES; b++)
                if (req_be[b]) merged_line[req_off][8*b +: 8] = req_wdata[8*b +: 8];
    end

    always_ff @(posedge clk_i) begin
        if (state == S_IDLE)
            for (int w = 0; w < WAYS; w++) begin
                tag_rd[w]  <= tag_mem[cpu_idx][w];
                rd_line[w] <= data_mem[cpu_idx][w];
            end
        if (!rst_i) begin
            if (state == S_INIT)
                for (int w = 0; w < WAYS; w++) tag_mem[init_cnt][w] <= '0;
            if (state == S_MERGE || (state == S_RESP && req_we)) begin
                tag_mem[req_idx][way_q]  <= tag_t'{dirty: req_we, valid: 1'b1, tag: req_tag};
                data_mem[req_idx][way_q] <= merged_line;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        cpu_done_o <= 1'b0;
        if (rst_i) begin
            state       <= S_INIT;
            init_cnt    <= '0;
            beat        <= '0;
            cpu_rdy_o   <= 1'b0;
            cpu_rdata_o <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    for (int w = 0; w < WAYS; w++) age_q[init_cnt][w] <= WAY_W'(w);
                    init_cnt <= init_cnt + INDEX_W'(1);
                    if (init_cnt == {INDEX_W{1'b1}}) begin
                        state     <= S_IDLE;
                        cpu_rdy_o <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!cpu_rdy_o) cpu_rdy_o <= 1'b1;
                    else if (cpu_req_i) begin
                        req_we    <= cpu_we_i;
                        req_be    <= cpu_be_i;
                        req_wdata <= cpu_wdata_i;
                        req_tag   <= cpu_addr_i[ADDR_W-1 -: TAG_W];
                        req_idx   <= cpu_idx;
                        req_off   <= cpu_addr_i[BO_W +: WO_W];
                        cpu_rdy_o <= 1'b0;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    way_q    <= sel_way;
                    line_buf <= rd_line[sel_way];
                    if (hit) state <= S_RESP;
                    else if (vic_dirty) begin
                        state       <= S_WB;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= {tag_rd[vic_way].tag, req_idx, {OFF_W{1'b0}}};
                        mem_wdata_o <= rd_line[vic_way][0];
                    end else begin
                        state      <= S_REFILL;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {req_tag, req_idx, {OFF_W{1'b0}}};
                    end
                end
                S_WB: if (mem_ack_i) begin
                    beat        <= beat_nx;
                    mem_wdata_o <= line_buf[beat_nx];
                    if (beat == WO_W'(WPL - 1)) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        state     <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    // After a write-back the refill burst opens one cycle later, leaving a low gap on mem_req_o.
                    if (!mem_req_o) begin
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= {req_tag, req_idx, {OFF_W{1'b0}}};
                    end else if (mem_ack_i) begin
                        line_buf[beat] <= mem_rdata_i;
                        beat           <= beat_nx;
                        if (beat == WO_W'(WPL - 1)) begin
                            mem_req_o <= 1'b0;
                            state     <= S_MERGE;
                        end
                    end
                end
                S_MERGE: begin
                    line_buf <= merged_line;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (!req_we) cpu_rdata_o <= line_buf[req_off];
                    cpu_done_o <= 1'b1;
                    for (int w = 0; w < WAYS; w++)
                        if (WAY_W'(w) == way_q) age_q[req_idx][w] <= '0;
                        else if (age_q[req_idx][w] < age_q[req_idx][way_q])
                            age_q[req_idx][w] <= age_q[req_idx][w] + WAY_W'(1);
                    state <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

`ifdef CACHE_WB_ASSOC_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_hit_o  <= '0;
            stat_miss_o <= '0;
            stat_wb_o   <= '0;
        end else if (state == S_LOOKUP) begin
            if (hit) begin
                if (stat_hit_o != 32'hFFFF_FFFF) stat_hit_o <= stat_hit_o + 32'd1;
            end else begin
                if (stat_miss_o != 32'hFFFF_FFFF) stat_miss_o <= stat_miss_o + 32'd1;
                if (vic_dirty && stat_wb_o != 32'hFFFF_FFFF) stat_wb_o <= stat_wb_o + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_cache_wb_assoc.sv
// Directed bench for cache_wb_assoc: init, miss/hit, byte-enable stores, dirty eviction, reset mid-burst.
// Memory side is modelled inside the access task; refill word i of line tag T is 0xA0 + 0x10*(T-1) + i.
module tb_cache_wb_assoc;
    logic        clk = 0;
    logic        rst_i = 1;
    logic        cpu_req_i = 0, cpu_we_i = 0;
    logic [3:0]  cpu_be_i = '0;
    logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
    logic        cpu_rdy_o, cpu_done_o;
    logic [31:0] cpu_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i = 0;
    logic [31:0] mem_rdata_i = '0;
`ifdef CACHE_WB_ASSOC_STATS_EN
    logic [31:0] stat_hit_o, stat_miss_o, stat_wb_o;
`endif

    int tests = 0, fails = 0;
    int lat, nbursts, rdy_after;
    bit overlap;
    logic [31:0] rd_data;
    logic [31:0] b_addr [2];
    logic        b_we   [2];
    int          b_beats[2];
    logic [31:0] wb_data[4];

    always #5 clk = ~clk;

    cache_wb_assoc dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_be_i(cpu_be_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_rdy_o(cpu_rdy_o), .cpu_done_o(cpu_done_o), .cpu_rdata_o(cpu_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
`ifdef CACHE_WB_ASSOC_STATS_EN
        , .stat_hit_o(stat_hit_o), .stat_miss_o(stat_miss_o), .stat_wb_o(stat_wb_o)
`endif
    );

    function automatic logic [31:0] refill_word(input logic [31:0] a, input int beat);
        return 32'hA0 + ({28'd0, a[15:12]} - 32'd1) * 32'h10 + 32'(beat);
    endfunction

    // Counts 'cpu_rdy_o low' samples from the current post-edge sample until it rises.
    task automatic count_init(output int cnt, output bit saw_req, input bit poke_cpu);
        cnt = 0; saw_req = 0;
        while (!cpu_rdy_o && cnt < 1000) begin
            if (mem_req_o) saw_req = 1;
            if (poke_cpu && cnt == 3) begin
                cpu_req_i = 1; cpu_addr_i = 32'h0000_7000; mem_ack_i = 1;
            end
            if (cnt == 20) begin cpu_req_i = 0; mem_ack_i = 0; end
            @(posedge clk); #1; cnt++;
        end
    endtask

    task automatic run_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit gap);
        int cyc, beat;
        bit prev_req, tog;
        nbursts = 0; overlap = 0; cyc = 0;
        b_beats[0] = 0; b_beats[1] = 0;
        while (!cpu_rdy_o && cyc < 50) begin @(posedge clk); #1; cyc++; end
        cpu_req_i = 1; cpu_we_i = we; cpu_be_i = be; cpu_addr_i = addr; cpu_wdata_i = wdata;
        @(posedge clk); #1;
        cpu_req_i = 0; cpu_we_i = ~we; cpu_be_i = 4'hF; cpu_addr_i = 32'hFFFF_FFF0; cpu_wdata_i = 32'h5555_AAAA;
        cyc = 1; prev_req = 0; tog = 0; beat = 0;
        while (!cpu_done_o && cyc < 200) begin
            if (cpu_rdy_o) overlap = 1;
            if (mem_req_o) begin
                if (!prev_req) begin
                    if (nbursts < 2) begin b_addr[nbursts] = mem_addr_o; b_we[nbursts] = mem_we_o; end
                    nbursts++; beat = 0; tog = 0;
                end
                if (gap && !tog) mem_ack_i = 0;
                else begin
                    mem_ack_i = 1;
                    if (mem_we_o) begin if (beat < 4) wb_data[beat] = mem_wdata_o; end
                    else mem_rdata_i = refill_word(mem_addr_o, beat);
                    beat++;
                    if (nbursts <= 2) b_beats[nbursts-1] = beat;
                end
                tog = !tog;
            end else mem_ack_i = 0;
            prev_req = mem_req_o;
            @(posedge clk); #1; cyc++;
        end
        mem_ack_i = 0;
        lat = cyc;
        rd_data = cpu_rdata_o;
        if (cpu_done_o && cpu_rdy_o) overlap = 1;
        tests++;
        if (!cpu_done_o) begin fails++; $display("FAIL timeout addr=%h: no cpu_done_o within %0d cycles", addr, cyc); end
        @(posedge clk); #1;
        rdy_after = cpu_rdy_o;
    endtask

    task automatic test_reset;
        int cnt; bit saw;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (cpu_rdy_o !== 1'b0) begin fails++; $display("FAIL rst_rdy got %b want 0", cpu_rdy_o); end
        tests++; if ({cpu_done_o, mem_req_o, mem_we_o} !== 3'b000) begin fails++; $display("FAIL rst_flags got %b want 000", {cpu_done_o, mem_req_o, mem_we_o}); end
        tests++; if ({cpu_rdata_o, mem_addr_o, mem_wdata_o} !== 96'd0) begin fails++; $display("FAIL rst_data got %h/%h/%h want 0", cpu_rdata_o, mem_addr_o, mem_wdata_o); end
        rst_i = 0;
        count_init(cnt, saw, 1'b1);
        tests++; if (cnt !== 256) begin fails++; $display("FAIL init_len got %0d want 256", cnt); end
        repeat (3) begin
            if (mem_req_o) saw = 1;
            @(posedge clk); #1;
        end
        tests++; if (saw !== 1'b0) begin fails++; $display("FAIL init_no_mem got mem_req seen=%b want 0", saw); end
        tests++; if (cpu_rdy_o !== 1'b1) begin fails++; $display("FAIL ignored_req got rdy=%b want 1", cpu_rdy_o); end
    endtask

    task automatic test_load_miss_hit;
        run_access(1'b0, 4'h0, 32'h0000_1004, 32'h0, 1'b0);
        tests++; if (rd_data !== 32'hA1) begin fails++; $display("FAIL miss_rdata got %h want 000000a1", rd_data); end
        tests++; if (lat !== 8) begin fails++; $display("FAIL miss_latency got %0d want 8", lat); end
        tests++; if (nbursts !== 1 || b_we[0] !== 1'b0 || b_addr[0] !== 32'h0000_1000 || b_beats[0] !== 4) begin
            fails++; $display("FAIL miss_burst got n=%0d we=%b addr=%h beats=%0d want 1/0/00001000/4", nbursts, b_we[0], b_addr[0], b_beats[0]); end
        tests++; if (overlap !== 1'b0 || rdy_after !== 1) begin fails++; $display("FAIL done_rdy got overlap=%b rdy_after=%0d want 0/1", overlap, rdy_after); end
        run_access(1'b0, 4'h0, 32'h0000_1004, 32'h0, 1'b0);
        tests++; if (lat !== 3 || nbursts !== 0) begin fails++; $display("FAIL hit_latency got lat=%0d bursts=%0d want 3/0", lat, nbursts); end
        tests++; if (rd_data !== 32'hA1) begin fails++; $display("FAIL hit_rdata got %h want 000000a1", rd_data); end
    endtask

    task automatic test_store;
        run_access(1'b1, 4'b0011, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0);
        tests++; if (lat !== 3 || nbursts !== 0) begin fails++; $display("FAIL store_hit got lat=%0d bursts=%0d want 3/0", lat, nbursts); end
        tests++; if (rd_data !== 32'hA1) begin fails++; $display("FAIL rdata_hold got %h want 000000a1", rd_data); end
        run_access(1'b0, 4'h0, 32'h0000_1004, 32'h0, 1'b0);
        tests++; if (rd_data !== 32'h0000_BEEF) begin fails++; $display("FAIL store_merge got %h want 0000beef", rd_data); end
        run_access(1'b1, 4'b0000, 32'h0000_1008, 32'hFFFF_FFFF, 1'b0);
        run_access(1'b0, 4'h0, 32'h0000_1008, 32'h0, 1'b0);
        tests++; if (rd_data !== 32'hA2) begin fails++; $display("FAIL be_zero got %h want 000000a2", rd_data); end
    endtask

    task automatic test_evict;
        logic [31:0] exp_wb [4];
        exp_wb[0] = 32'hA0; exp_wb[1] = 32'h0000_BEEF; exp_wb[2] = 32'hA2; exp_wb[3] = 32'hA3;
        for (int t = 2; t <= 4; t++) begin
            run_access(1'b0, 4'h0, 32'(t) << 12, 32'h0, 1'b0);
            tests++; if (rd_data !== refill_word(32'(t) << 12, 0) || nbursts !== 1 || b_we[0] !== 1'b0) begin
                fails++; $display("FAIL fill_tag%0d got rd=%h n=%0d we=%b want %h/1/0", t, rd_data, nbursts, b_we[0], refill_word(32'(t) << 12, 0)); end
        end
        run_access(1'b0, 4'h0, 32'h0000_5004, 32'h0, 1'b1);
        tests++; if (nbursts !== 2 || b_we[0] !== 1'b1 || b_addr[0] !== 32'h0000_1000 || b_beats[0] !== 4) begin
            fails++; $display("FAIL wb_burst got n=%0d we=%b addr=%h beats=%0d want 2/1/00001000/4", nbursts, b_we[0], b_addr[0], b_beats[0]); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (wb_data[i] !== exp_wb[i]) begin fails++; $display("FAIL wb_beat%0d got %h want %h", i, wb_data[i], exp_wb[i]); end
        end
        tests++; if (b_we[1] !== 1'b0 || b_addr[1] !== 32'h0000_5000 || b_beats[1] !== 4 || rd_data !== 32'hE1) begin
            fails++; $display("FAIL evict_refill got we=%b addr=%h beats=%0d rd=%h want 0/00005000/4/000000e1", b_we[1], b_addr[1], b_beats[1], rd_data); end
        run_access(1'b0, 4'h0, 32'h0000_2000, 32'h0, 1'b0);
        tests++; if (lat !== 3 || rd_data !== 32'hB0) begin fails++; $display("FAIL lru_keep got lat=%0d rd=%h want 3/000000b0", lat, rd_data); end
`ifdef CACHE_WB_ASSOC_STATS_EN
        tests++; if (stat_hit_o !== 32'd6 || stat_miss_o !== 32'd5 || stat_wb_o !== 32'd1) begin
            fails++; $display("FAIL stats got hit=%0d miss=%0d wb=%0d want 6/5/1", stat_hit_o, stat_miss_o, stat_wb_o); end
`endif
    endtask

    task automatic test_reset_mid_burst;
        int cyc, beat, cnt; bit saw;
        cyc = 0; beat = 0;
        while (!cpu_rdy_o && cyc < 50) begin @(posedge clk); #1; cyc++; end
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h0000_6000;
        @(posedge clk); #1;
        cpu_req_i = 0; cyc = 0;
        while (cyc < 40 && !rst_i) begin
            if (mem_req_o) begin
                mem_ack_i = 1; mem_rdata_i = refill_word(mem_addr_o, beat);
                if (beat == 1) rst_i = 1;
                beat++;
            end else mem_ack_i = 0;
            @(posedge clk); #1; cyc++;
        end
        mem_ack_i = 0;
        tests++; if (rst_i !== 1'b1 || mem_req_o !== 1'b0 || cpu_rdy_o !== 1'b0) begin
            fails++; $display("FAIL abort got rst=%b mem_req=%b rdy=%b want 1/0/0", rst_i, mem_req_o, cpu_rdy_o); end
        rst_i = 0;
        count_init(cnt, saw, 1'b0);
        tests++; if (cnt !== 256 || saw !== 1'b0) begin fails++; $display("FAIL reinit got %0d mem_req=%b want 256/0", cnt, saw); end
        run_access(1'b0, 4'h0, 32'h0000_6000, 32'h0, 1'b0);
        tests++; if (nbursts !== 1 || lat !== 8 || rd_data !== 32'hF0) begin
            fails++; $display("FAIL post_reset_miss got n=%0d lat=%0d rd=%h want 1/8/000000f0", nbursts, lat, rd_data); end
    endtask

    initial begin
        test_reset;
        test_load_miss_hit;
        test_store;
        test_evict;
        test_reset_mid_burst;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
